// File: rtl/fb_arbiter_pkg.sv
// Shared VGA/framebuffer constants and the RAM slot type used by the framebuffer arbiter.
package fb_arbiter_pkg;

  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int FB_ADDR_W  = 19;
  localparam int FB_DATA_W  = 12;
  localparam int PX_DIV     = 4;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_READ  = 2'd1,
    SLOT_WRITE = 2'd2
  } slot_e;

endpackage

// File: rtl/fifo2.sv
// Two-entry register FIFO with the head always visible on dout.
// A push while full or a pop while empty is ignored.
module fifo2 #(
  parameter int W = 31
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// Shares one single-port framebuffer RAM between VGA scanout reads (hard priority)
// and a buffered pixel writer that fills every RAM cycle the scanout leaves free.
module fb_arbiter
  import fb_arbiter_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W,
  parameter int RD_LAT = 1,
  parameter int PX_DIV = fb_arbiter_pkg::PX_DIV
) (
  input  logic              clk,
  input  logic              i_arst_n,
  input  logic              i_px_clk,
  input  logic              i_disp_en,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic [DATA_W-1:0] o_disp_data,
  output logic              o_disp_valid,
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata,
  input  logic              i_clr_err,
  output logic              o_overlap_err
);

  localparam int WORD_W = ADDR_W + DATA_W;

  generate
    if (RD_LAT < 1 || RD_LAT + 2 > PX_DIV) begin : g_bad_rd_lat
      $error("fb_arbiter: RD_LAT must be at least 1 and RD_LAT+2 must not exceed PX_DIV");
    end
    if ((2 ** ADDR_W) < H_ACTIVE * V_ACTIVE) begin : g_bad_addr_w
      $error("fb_arbiter: ADDR_W too small to address the visible framebuffer");
    end
  endgenerate

  slot_e             slot_next;
  logic              disp_req;
  logic              wr_fire;
  logic              issue_wr;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [1:0]        fifo_count;
  logic [1:0]        count_next;
  logic [WORD_W-1:0] fifo_head;
  logic [WORD_W-1:0] wr_word;
  logic [RD_LAT:0]   rd_pipe;

  assign disp_req = i_px_clk & i_disp_en;
  assign wr_fire  = i_wr_valid & o_wr_ready;

  // The scanout claims the next RAM cycle outright; otherwise any pending or incoming write takes it.
  always_comb begin
    slot_next = SLOT_IDLE;
    if (disp_req) begin
      slot_next = SLOT_READ;
    end else if (!fifo_empty || wr_fire) begin
      slot_next = SLOT_WRITE;
    end
  end

  // With nothing queued, an accepted write goes straight to the RAM and never occupies the FIFO.
  assign issue_wr   = (slot_next == SLOT_WRITE);
  assign wr_word    = fifo_empty ? {i_wr_addr, i_wr_data} : fifo_head;
  assign fifo_push  = wr_fire & ~fifo_full & ~(fifo_empty & issue_wr);
  assign fifo_pop   = issue_wr & ~fifo_empty;
  assign count_next = fifo_count + {1'b0, fifo_push} - {1'b0, fifo_pop};

  fifo2 #(
    .W(WORD_W)
  ) u_wr_fifo (
    .clk  (clk),
    .rst_n(i_arst_n),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  ({i_wr_addr, i_wr_data}),
    .dout (fifo_head),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // RAM command, read-tracking pipe, pixel capture, writer handshake and the sticky overlap flag.
  always_ff @(posedge clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_ram_en      <= 1'b0;
      o_ram_we      <= 1'b0;
      o_ram_addr    <= '0;
      o_ram_wdata   <= '0;
      rd_pipe       <= '0;
      o_disp_valid  <= 1'b0;
      o_disp_data   <= '0;
      o_wr_ready    <= 1'b0;
      o_overlap_err <= 1'b0;
    end else begin
      o_ram_en <= (slot_next != SLOT_IDLE);
      o_ram_we <= issue_wr;
      if (slot_next == SLOT_READ) begin
        o_ram_addr <= i_disp_addr;
      end else if (issue_wr) begin
        o_ram_addr  <= wr_word[WORD_W-1 -: ADDR_W];
        o_ram_wdata <= wr_word[DATA_W-1:0];
      end
      rd_pipe      <= {rd_pipe[RD_LAT-1:0], disp_req};
      o_disp_valid <= rd_pipe[RD_LAT];
      if (rd_pipe[RD_LAT]) begin
        o_disp_data <= i_ram_rdata;
      end
      o_wr_ready <= (count_next < 2'(FIFO_DEPTH));
      if (i_px_clk && (|rd_pipe)) begin
        o_overlap_err <= 1'b1;
      end else if (i_clr_err) begin
        o_overlap_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: directed phases and randomized traffic checked every cycle
// against a queue-based model of slot ownership, write ordering and pixel return timing.
module tb_fb_arbiter;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 12;
  localparam int RD_LAT = 1;
  localparam int PX_DIV = 4;

  logic              clk = 1'b0;
  logic              i_arst_n;
  logic              i_px_clk;
  logic              i_disp_en;
  logic [ADDR_W-1:0] i_disp_addr;
  logic [DATA_W-1:0] o_disp_data;
  logic              o_disp_valid;
  logic              i_wr_valid;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [DATA_W-1:0] i_wr_data;
  logic              o_wr_ready;
  logic              o_ram_en;
  logic              o_ram_we;
  logic [ADDR_W-1:0] o_ram_addr;
  logic [DATA_W-1:0] o_ram_wdata;
  logic [DATA_W-1:0] i_ram_rdata;
  logic              i_clr_err;
  logic              o_overlap_err;

  always #5 clk = ~clk;

  fb_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT),
    .PX_DIV(PX_DIV)
  ) dut (
    .clk          (clk),
    .i_arst_n     (i_arst_n),
    .i_px_clk     (i_px_clk),
    .i_disp_en    (i_disp_en),
    .i_disp_addr  (i_disp_addr),
    .o_disp_data  (o_disp_data),
    .o_disp_valid (o_disp_valid),
    .i_wr_valid   (i_wr_valid),
    .i_wr_addr    (i_wr_addr),
    .i_wr_data    (i_wr_data),
    .o_wr_ready   (o_wr_ready),
    .o_ram_en     (o_ram_en),
    .o_ram_we     (o_ram_we),
    .o_ram_addr   (o_ram_addr),
    .o_ram_wdata  (o_ram_wdata),
    .i_ram_rdata  (i_ram_rdata),
    .i_clr_err    (i_clr_err),
    .o_overlap_err(o_overlap_err)
  );

  // Behavioural single-port RAM with a one-cycle registered read.
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    if (o_ram_en) begin
      if (o_ram_we) ram[o_ram_addr] <= o_ram_wdata;
      else i_ram_rdata <= ram[o_ram_addr];
    end
  end

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct {
    int                cyc;
    logic [DATA_W-1:0] data;
  } rd_t;

  // Model state: pending writes in acceptance order, due pixel returns, recent read pulses.
  wr_t               wq[$];
  rd_t               vq[$];
  int                pulses[$];
  logic [DATA_W-1:0] fb [0:(1<<ADDR_W)-1];
  int                cyc;
  int                checks;
  int                errors;
  logic              m_en, m_we, m_ready, m_err, m_acc;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_disp;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s at cycle %0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_output();
    logic exp_v;
    exp_v = 1'b0;
    if (vq.size() > 0 && vq[0].cyc == cyc) begin
      exp_v  = 1'b1;
      m_disp = vq[0].data;
      vq.delete(0);
    end
    check_val("ram_en", 32'(o_ram_en), 32'(m_en));
    check_val("ram_we", 32'(o_ram_we), 32'(m_we));
    if (m_en) check_val("ram_addr", 32'(o_ram_addr), 32'(m_addr));
    if (m_we) check_val("ram_wdata", 32'(o_ram_wdata), 32'(m_wdata));
    check_val("disp_valid", 32'(o_disp_valid), 32'(exp_v));
    check_val("disp_data", 32'(o_disp_data), 32'(m_disp));
    check_val("wr_ready", 32'(o_wr_ready), 32'(m_ready));
    check_val("overlap_err", 32'(o_overlap_err), 32'(m_err));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ram_en"}, 32'(o_ram_en), 32'(0));
    check_val({tag, "_ram_we"}, 32'(o_ram_we), 32'(0));
    check_val({tag, "_ram_addr"}, 32'(o_ram_addr), 32'(0));
    check_val({tag, "_ram_wdata"}, 32'(o_ram_wdata), 32'(0));
    check_val({tag, "_disp_data"}, 32'(o_disp_data), 32'(0));
    check_val({tag, "_disp_valid"}, 32'(o_disp_valid), 32'(0));
    check_val({tag, "_wr_ready"}, 32'(o_wr_ready), 32'(0));
    check_val({tag, "_overlap_err"}, 32'(o_overlap_err), 32'(0));
  endtask

  task automatic model_reset();
    wq.delete();
    vq.delete();
    pulses.delete();
    m_en = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    m_ready = 1'b0; m_err = 1'b0; m_disp = '0; m_acc = 1'b0;
  endtask

  // Drives one cycle of inputs and predicts the RAM slot, handshake and flag for the next cycle.
  task automatic apply_stimulus(input bit px, input bit de, input logic [ADDR_W-1:0] da,
                                input bit wv, input logic [ADDR_W-1:0] wa,
                                input logic [DATA_W-1:0] wd, input bit clr);
    bit inflight;
    i_px_clk = px; i_disp_en = de; i_disp_addr = da;
    i_wr_valid = wv; i_wr_addr = wa; i_wr_data = wd; i_clr_err = clr;
    while (pulses.size() > 0 && cyc - pulses[0] > RD_LAT + 1) pulses.delete(0);
    inflight = 1'b0;
    foreach (pulses[i]) begin
      if (cyc - pulses[i] >= 1 && cyc - pulses[i] <= RD_LAT + 1) inflight = 1'b1;
    end
    if (px && inflight) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    m_acc = wv && m_ready;
    if (m_acc) wq.push_back('{wa, wd});
    m_en = 1'b0;
    m_we = 1'b0;
    if (px && de) begin
      pulses.push_back(cyc);
      m_en   = 1'b1;
      m_addr = da;
      vq.push_back('{cyc + 2 + RD_LAT, fb[da]});
    end else if (wq.size() > 0) begin
      m_en    = 1'b1;
      m_we    = 1'b1;
      m_addr  = wq[0].addr;
      m_wdata = wq[0].data;
      fb[m_addr] = m_wdata;
      wq.delete(0);
    end
    m_ready = (wq.size() < 2);
  endtask

  task automatic run_cycle(input bit px, input bit de, input logic [ADDR_W-1:0] da,
                           input bit wv, input logic [ADDR_W-1:0] wa,
                           input logic [DATA_W-1:0] wd, input bit clr);
    @(negedge clk);
    cyc++;
    check_output();
    apply_stimulus(px, de, da, wv, wa, wd, clr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic px_cycle(input logic [ADDR_W-1:0] da, input bit clr);
    run_cycle(1'b1, 1'b1, da, 1'b0, '0, '0, clr);
  endtask

  task automatic release_reset();
    @(negedge clk);
    i_arst_n = 1'b1;
    cyc++;
    check_output();
    apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  logic              rv;
  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rd;

  initial begin
    checks = 0; errors = 0; cyc = 0;
    i_px_clk = 1'b0; i_disp_en = 1'b0; i_disp_addr = '0;
    i_wr_valid = 1'b0; i_wr_addr = '0; i_wr_data = '0; i_clr_err = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      ram[i] = '0;
      fb[i]  = '0;
    end
    model_reset();
    i_arst_n = 1'b0;
    #12;
    check_reset_outputs("reset");
    release_reset();

    $display("[TB] single scanout read of a preloaded pixel");
    ram[19'h10] = 12'hABC; fb[19'h10] = 12'hABC;
    idle(1);
    px_cycle(19'h10, 1'b0);
    idle(4);
    run_cycle(1'b1, 1'b0, 19'h20, 1'b0, '0, '0, 1'b0);
    idle(4);

    $display("[TB] back-to-back writer burst");
    for (int i = 0; i < 6; i++) begin
      run_cycle(1'b0, 1'b0, '0, 1'b1, ADDR_W'(32'h100 + i), DATA_W'(i + 1), 1'b0);
    end
    idle(3);

    $display("[TB] saturated writer against periodic scanout");
    ra = ADDR_W'(32'h200 + $urandom_range(0, 15));
    rd = DATA_W'($urandom);
    for (int i = 0; i < 40; i++) begin
      run_cycle((i % PX_DIV) == 0, 1'b1, ADDR_W'(32'h200 + $urandom_range(0, 15)),
                1'b1, ra, rd, 1'b0);
      if (m_acc) begin
        ra = ADDR_W'(32'h200 + $urandom_range(0, 15));
        rd = DATA_W'($urandom);
      end
    end
    idle(6);

    $display("[TB] read and write to the same address in the same cycle");
    ram[19'h300] = 12'h123; fb[19'h300] = 12'h123;
    run_cycle(1'b1, 1'b1, 19'h300, 1'b1, 19'h300, 12'h5A5, 1'b0);
    idle(4);
    px_cycle(19'h300, 1'b0);
    idle(4);

    $display("[TB] overlapping pixel pulses and error clear");
    px_cycle(19'h100, 1'b0);
    idle(1);
    px_cycle(19'h101, 1'b0);
    idle(4);
    run_cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1);
    idle(2);
    px_cycle(19'h102, 1'b0);
    idle(1);
    px_cycle(19'h103, 1'b1);
    idle(4);
    run_cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1);
    idle(2);

    $display("[TB] asynchronous reset with writes queued and a read in flight");
    run_cycle(1'b1, 1'b1, 19'h104, 1'b1, 19'h400, 12'h0AA, 1'b0);
    run_cycle(1'b1, 1'b1, 19'h105, 1'b1, 19'h401, 12'h0BB, 1'b0);
    @(negedge clk);
    #2;
    i_arst_n = 1'b0;
    i_px_clk = 1'b0; i_disp_en = 1'b0; i_wr_valid = 1'b0; i_clr_err = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    repeat (2) @(negedge clk);
    release_reset();
    idle(8);
    px_cycle(19'h400, 1'b0);
    idle(4);
    px_cycle(19'h401, 1'b0);
    idle(4);

    $display("[TB] randomized mixed traffic");
    rv = 1'b0; ra = '0; rd = '0;
    for (int i = 0; i < 80; i++) begin
      if (!rv || m_acc) begin
        rv = ($urandom_range(0, 3) != 0);
        ra = ADDR_W'(32'h400 + $urandom_range(0, 7));
        rd = DATA_W'($urandom);
      end
      run_cycle((i % PX_DIV) == 1, 1'($urandom_range(0, 1)),
                ADDR_W'(32'h400 + $urandom_range(0, 7)), rv, ra, rd, 1'b0);
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
